// File: rtl/core_wr_arb.sv
// Round-robin write arbiter: CORE_CNT cores share one registered memory write bus.
// Optional write counter output wr_cnt enabled by defining CORE_WR_ARB_WCNT_EN.
module core_wr_arb #(
    parameter int CORE_CNT = 4,
    parameter int ADDR_WID = 32,
    parameter int DATA_WID = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CORE_CNT-1:0]          core_mask,
    input  logic [CORE_CNT-1:0]          req,
    input  logic [CORE_CNT*ADDR_WID-1:0] req_addr,
    input  logic [CORE_CNT*DATA_WID-1:0] req_data,
    output logic [CORE_CNT-1:0]          ack,
    output logic [CORE_CNT-1:0]          cpu_en,
    output logic                         mem_we,
    output logic [ADDR_WID-1:0]          mem_addr,
    output logic [DATA_WID-1:0]          mem_data
`ifdef CORE_WR_ARB_WCNT_EN
    ,
    output logic [31:0]                  wr_cnt
`endif
);

    localparam int PTR_W = (CORE_CNT > 1) ? $clog2(CORE_CNT) : 1;

    logic [CORE_CNT-1:0] ack_q, ack_d;
    logic                we_q, we_d;
    logic [ADDR_WID-1:0] addr_q, addr_d;
    logic [DATA_WID-1:0] data_q, data_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [CORE_CNT-1:0] elig_s;
    logic                found_s;
    logic [PTR_W-1:0]    win_s;

    // Round-robin search from ptr; the core acked last edge is excluded so its stale request is not taken twice
    always_comb begin : sel_blk
        int idx;
        elig_s  = req & core_mask & ~ack_q;
        found_s = 1'b0;
        win_s   = '0;
        idx     = 0;
        for (int k = 0; k < CORE_CNT; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= CORE_CNT) begin
                idx = idx - CORE_CNT;
            end else begin
                idx = idx;
            end
            if (!found_s && elig_s[idx]) begin
                found_s = 1'b1;
                win_s   = PTR_W'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state of the write bus, ack and pointer
    always_comb begin
        ack_d  = '0;
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        ptr_d  = ptr_q;
        if (found_s) begin
            we_d   = 1'b1;
            ack_d  = CORE_CNT'(1) << win_s;
            addr_d = req_addr[int'(win_s)*ADDR_WID +: ADDR_WID];
            data_d = req_data[int'(win_s)*DATA_WID +: DATA_WID];
            if (win_s == PTR_W'(CORE_CNT-1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_s + PTR_W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // State registers; reset discards any write in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            ptr_q  <= '0;
        end else begin
            ack_q  <= ack_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            ptr_q  <= ptr_d;
        end
    end

`ifdef CORE_WR_ARB_WCNT_EN
    logic [31:0] wcnt_q, wcnt_d;

    // Count every edge that launches a write; wraps naturally at 32 bits
    always_comb begin
        if (we_d) begin
            wcnt_d = wcnt_q + 32'd1;
        end else begin
            wcnt_d = wcnt_q;
        end
    end

    // Write counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt_q <= 32'd0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign wr_cnt = wcnt_q;
`endif

    assign ack      = ack_q;
    assign mem_we   = we_q;
    assign mem_addr = addr_q;
    assign mem_data = data_q;
    // A waiting core stalls until its ack cycle; a masked core is always stalled
    assign cpu_en   = core_mask & (~req | ack_q);

endmodule

// File: tb/tb_core_wr_arb.sv
// Randomized and directed bench for core_wr_arb against a behavioural round-robin model.
module tb_core_wr_arb;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  core_mask;
    logic [N-1:0]  req;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  ack;
    logic [N-1:0]  cpu_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
`ifdef CORE_WR_ARB_WCNT_EN
    logic [31:0]   wr_cnt;
`endif

    core_wr_arb #(.CORE_CNT(N), .ADDR_WID(AW), .DATA_WID(DW)) dut (
        .clk(clk), .rst(rst), .core_mask(core_mask), .req(req),
        .req_addr(req_addr), .req_data(req_data), .ack(ack), .cpu_en(cpu_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data)
`ifdef CORE_WR_ARB_WCNT_EN
        , .wr_cnt(wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [N-1:0]  m_ack;
    int            m_ptr;
    logic [31:0]   m_cnt;

    // per-core stimulus
    logic [N-1:0]  c_req;
    logic [AW-1:0] c_addr [N];
    logic [DW-1:0] c_data [N];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_we = 1'b0; m_addr = '0; m_data = '0; m_ack = '0; m_ptr = 0; m_cnt = 32'd0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i] = c_req[i];
            req_addr[i*AW +: AW] = c_addr[i];
            req_data[i*DW +: DW] = c_data[i];
        end
    endtask

    task automatic new_req(input int i);
        c_req[i]  = 1'b1;
        c_addr[i] = $urandom;
        c_data[i] = $urandom;
    endtask

    // one clock: check run enables, predict the edge, check the bus
    task automatic step();
        int w;
        drive();
        #1;
        check_val("cpu_en", cpu_en, core_mask & (~c_req | m_ack));
        w = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (w < 0 && c_req[i] && core_mask[i] && !m_ack[i]) w = i;
        end
        @(posedge clk);
        if (w >= 0) begin
            m_we = 1'b1; m_addr = c_addr[w]; m_data = c_data[w];
            m_ack = N'(1) << w; m_ptr = (w + 1) % N; m_cnt = m_cnt + 32'd1;
        end else begin
            m_we = 1'b0; m_ack = '0;
        end
        @(negedge clk);
        check_val("mem_we", mem_we, m_we);
        check_val("ack", ack, m_ack);
        check_val("mem_addr", mem_addr, m_addr);
        check_val("mem_data", mem_data, m_data);
`ifdef CORE_WR_ARB_WCNT_EN
        check_val("wr_cnt", wr_cnt, m_cnt);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b0;
        c_req = '0;
        drive();
        model_reset();
        #1;
        check_val("rst_we", mem_we, 1'b0);
        check_val("rst_ack", ack, '0);
        check_val("rst_addr", mem_addr, '0);
        check_val("rst_data", mem_data, '0);
        @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    int wait_cnt [N];
    int max_wait;
    logic [N-1:0] prev_ack;

    initial begin
        rst = 1'b1;
        core_mask = 4'hF;
        c_req = '0;
        for (int i = 0; i < N; i++) begin
            c_addr[i] = '0;
            c_data[i] = '0;
        end
        drive();
        #2;
        do_reset();

        // single write from core 2
        c_addr[2] = 32'h100; c_data[2] = 32'hDEADBEEF; c_req[2] = 1'b1;
        drive(); #1;
        check_val("single_stall", cpu_en[2], 1'b0);
        step();
        check_val("single_ack", ack, 4'b0100);
        check_val("single_addr", mem_addr, 32'h100);
        check_val("single_data", mem_data, 32'hDEADBEEF);
        check_val("single_en_ack", cpu_en[2], 1'b1);
        c_req[2] = 1'b0;
        step();

        // simultaneous requests from reset: 0 then 1, pointer left at 2
        do_reset();
        new_req(0); new_req(1);
        step();
        check_val("simul_first", ack, 4'b0001);
        c_req[0] = 1'b0;
        step();
        check_val("simul_second", ack, 4'b0010);
        c_req[1] = 1'b0;
        new_req(0); new_req(3);
        step();
        check_val("ptr_at_2", ack, 4'b1000);
        c_req[3] = 1'b0;
        step();
        c_req[0] = 1'b0;
        step();

        // masking: core 2 excluded then re-enabled
        core_mask = 4'b1011;
        new_req(2);
        for (int t = 0; t < 3; t++) begin
            step();
            check_val("mask_no_we", mem_we, 1'b0);
            check_val("mask_stall", cpu_en[2], 1'b0);
        end
        core_mask = 4'hF;
        step();
        check_val("unmask_grant", ack, 4'b0100);
        c_req[2] = 1'b0;
        step();

        // saturation: every core always requesting, new data on each ack
        for (int i = 0; i < N; i++) begin
            new_req(i);
            wait_cnt[i] = 0;
        end
        max_wait = 0;
        prev_ack = '0;
        for (int t = 0; t < 40; t++) begin
            step();
            if (t > 0) check_val("sat_we", mem_we, 1'b1);
            check_val("sat_b2b", ack & prev_ack, '0);
            prev_ack = ack;
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    wait_cnt[i] = 0;
                    new_req(i);
                end else begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                end
            end
        end
        check_val("sat_fair", (max_wait >= N), 1'b0);

        // reset while a write is on the bus
        check_val("pre_rst_we", mem_we, 1'b1);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check_val("midrst_we", mem_we, 1'b0);
        check_val("midrst_ack", ack, '0);
        check_val("midrst_addr", mem_addr, '0);
        check_val("midrst_data", mem_data, '0);
        check_val("midrst_cpu_en", cpu_en, core_mask & ~c_req);
        #1;
        rst = 1'b1;
        step();
        check_val("restart_core0", ack, 4'b0001);

        // randomized traffic with occasional mask changes
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (m_ack[i]) begin
                    if ($urandom_range(1, 0) == 1) new_req(i);
                    else c_req[i] = 1'b0;
                end else if (!c_req[i] && $urandom_range(2, 0) == 0) begin
                    new_req(i);
                end else begin
                    c_req[i] = c_req[i];
                end
            end
            if ($urandom_range(7, 0) == 0) core_mask = N'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
